// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
// Forwarding and hazard unit for the five-stage MIPS pipeline, sitting next to
// the ID stage. It keeps a DEPTH-entry history of in-flight destination
// registers. Each entry has a readiness countdown. From that history it
// produces forward selects for the ID branch comparator, registered forward
// selects for the ALU operands in EX, and one stall request.
//
// Parameters
//   DEPTH    history entries (min 2); index 0 = instruction in EX,
//            index i>=1 = result held in forwarding source i
//   REG_AW   register-address width
//   LOAD_LAT extra cycles a load result trails an ALU result (0..2)
//   SELW     derived select width, clog2(DEPTH)
//
// Ports
//   CLK, RESET                 clock, synchronous active-high reset
//   id_valid, flush_id         ID holds a real / squashed instruction
//   id_rs, id_rt               source registers
//   id_use_rs, id_use_rt       source actually read
//   id_branch                  ID instruction compares rs/rt in ID
//   id_wr_en, id_wr_reg        destination write enable / register
//   id_load                    ID instruction is a load
//   stall                      combinational; hold PC and IF/ID, bubble to EX
//   fwd_cmp_rs/rt_sel          combinational comparator selects
//                              (0 = regfile, k = source k)
//   fwd_alu_rs/rt_sel          registered ALU selects for the EX instruction
//
// Build option
//   FWD_BRANCH_CMP_EN  when defined, branch operands are forwarded into the
//                      ID comparator. When it is undefined, the comparator
//                      selects are tied to 0 and a branch waits until every
//                      matching producer has retired.
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
   parameter  int unsigned DEPTH    = 3,
   parameter  int unsigned REG_AW   = 5,
   parameter  int unsigned LOAD_LAT = 1,
   localparam int unsigned SELW     = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              id_valid,
   input  logic              flush_id,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_branch,
   input  logic              id_wr_en,
   input  logic [REG_AW-1:0] id_wr_reg,
   input  logic              id_load,
   output logic              stall,
   output logic [SELW-1:0]   fwd_cmp_rs_sel,
   output logic [SELW-1:0]   fwd_cmp_rt_sel,
   output logic [SELW-1:0]   fwd_alu_rs_sel,
   output logic [SELW-1:0]   fwd_alu_rt_sel
);

   localparam int unsigned CW = 2;

   typedef struct packed {
      logic            hit;
      logic [SELW-1:0] idx;
      logic [CW-1:0]   cnt;
   } match_t;

   // History state
   logic [DEPTH-1:0]             vld_q, vld_d;
   logic [DEPTH-1:0][REG_AW-1:0] reg_q, reg_d;
   logic [DEPTH-1:0][CW-1:0]     cnt_q, cnt_d;
   logic [SELW-1:0]              fwd_alu_rs_sel_q, fwd_alu_rs_sel_d;
   logic [SELW-1:0]              fwd_alu_rt_sel_q, fwd_alu_rt_sel_d;

   logic [DEPTH-1:0] rs_hits, rt_hits;
   match_t           alu_rs_m, alu_rt_m;
   logic             alu_haz, cmp_haz, insert_real, bubble;

   // Youngest (lowest index) hit at or below index 'last'
   function automatic match_t youngest(input logic [DEPTH-1:0]         hits,
                                       input logic [DEPTH-1:0][CW-1:0] cnts,
                                       input int                       last);
      match_t m;
      m = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (hits[i] && (i <= last)) begin
            m.hit = 1'b1;
            m.idx = SELW'(i);
            m.cnt = cnts[i];
         end
      end
      return m;
   endfunction

   // Per-entry source matches; r0 and unused sources never match
   always_comb begin
      rs_hits = '0;
      rt_hits = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         rs_hits[i] = vld_q[i] & (reg_q[i] == id_rs) & (id_rs != '0) & id_use_rs;
         rt_hits[i] = vld_q[i] & (reg_q[i] == id_rt) & (id_rt != '0) & id_use_rt;
      end
   end

   // ALU operand check: a youngest producer with cnt>=2 is a load-use hazard
   always_comb begin
      alu_rs_m = youngest(rs_hits, cnt_q, int'(DEPTH) - 2);
      alu_rt_m = youngest(rt_hits, cnt_q, int'(DEPTH) - 2);
      alu_haz  = (alu_rs_m.hit & (alu_rs_m.cnt >= CW'(2))) |
                 (alu_rt_m.hit & (alu_rt_m.cnt >= CW'(2)));
   end

`ifdef FWD_BRANCH_CMP_EN
   match_t cmp_rs_m, cmp_rt_m;
   logic   cmp_rs_haz, cmp_rt_haz;

   // Comparator check: the producer must have left EX and be fully ready
   always_comb begin
      cmp_rs_m   = youngest(rs_hits, cnt_q, int'(DEPTH) - 1);
      cmp_rt_m   = youngest(rt_hits, cnt_q, int'(DEPTH) - 1);
      cmp_rs_haz = id_branch & cmp_rs_m.hit &
                   ((cmp_rs_m.idx == '0) | (cmp_rs_m.cnt != '0));
      cmp_rt_haz = id_branch & cmp_rt_m.hit &
                   ((cmp_rt_m.idx == '0) | (cmp_rt_m.cnt != '0));
      cmp_haz    = cmp_rs_haz | cmp_rt_haz;
      fwd_cmp_rs_sel = '0;
      fwd_cmp_rt_sel = '0;
      if (id_branch && cmp_rs_m.hit && !cmp_rs_haz) fwd_cmp_rs_sel = cmp_rs_m.idx;
      if (id_branch && cmp_rt_m.hit && !cmp_rt_haz) fwd_cmp_rt_sel = cmp_rt_m.idx;
   end
`else
   // No comparator forwarding: a branch waits until its producers retire
   always_comb begin
      cmp_haz        = id_branch & ((|rs_hits) | (|rt_hits));
      fwd_cmp_rs_sel = '0;
      fwd_cmp_rt_sel = '0;
   end
`endif

   // Stall request and next ALU selects; a bubble entering EX gets sel 0
   always_comb begin
      stall            = (alu_haz | cmp_haz) & id_valid & ~flush_id;
      bubble           = stall | flush_id | ~id_valid;
      fwd_alu_rs_sel_d = '0;
      fwd_alu_rt_sel_d = '0;
      if (!bubble && alu_rs_m.hit) fwd_alu_rs_sel_d = SELW'(alu_rs_m.idx + SELW'(1));
      if (!bubble && alu_rt_m.hit) fwd_alu_rt_sel_d = SELW'(alu_rt_m.idx + SELW'(1));
   end

   // History shift: insert at 0, age every entry, drop the oldest
   always_comb begin
      vld_d       = '0;
      reg_d       = '0;
      cnt_d       = '0;
      insert_real = id_valid & id_wr_en & (id_wr_reg != '0) & ~flush_id & ~stall;
      vld_d[0]    = insert_real;
      if (insert_real) begin
         reg_d[0] = id_wr_reg;
         cnt_d[0] = id_load ? CW'(1 + LOAD_LAT) : CW'(1);
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
         vld_d[i] = vld_q[i-1];
         reg_d[i] = reg_q[i-1];
         cnt_d[i] = (cnt_q[i-1] == '0) ? '0 : CW'(cnt_q[i-1] - CW'(1));
      end
   end

   // State registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         vld_q            <= '0;
         reg_q            <= '0;
         cnt_q            <= '0;
         fwd_alu_rs_sel_q <= '0;
         fwd_alu_rt_sel_q <= '0;
      end else begin
         vld_q            <= vld_d;
         reg_q            <= reg_d;
         cnt_q            <= cnt_d;
         fwd_alu_rs_sel_q <= fwd_alu_rs_sel_d;
         fwd_alu_rt_sel_q <= fwd_alu_rt_sel_d;
      end
   end

   assign fwd_alu_rs_sel = fwd_alu_rs_sel_q;
   assign fwd_alu_rt_sel = fwd_alu_rt_sel_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
// Directed, table-driven bench for fwd_hazard_unit (DEPTH=3, LOAD_LAT=1),
// with a second instance at LOAD_LAT=2 for the longer load-use stall.
// Expectations for branch rows follow the FWD_BRANCH_CMP_EN build setting.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

`ifdef FWD_BRANCH_CMP_EN
   localparam int C = 1;
`else
   localparam int C = 0;
`endif
   localparam int NC = 1 - C;

   logic       CLK;
   logic       RESET;
   logic       id_valid, flush_id;
   logic [4:0] id_rs, id_rt, id_wr_reg;
   logic       id_use_rs, id_use_rt, id_branch, id_wr_en, id_load;
   logic       stall, stall2;
   logic [1:0] cmp_rs, cmp_rt, alu_rs, alu_rt;
   logic [1:0] cmp_rs2, cmp_rt2, alu_rs2, alu_rt2;

   fwd_hazard_unit u_dut (
      .CLK(CLK), .RESET(RESET), .id_valid(id_valid), .flush_id(flush_id),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_branch(id_branch), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
      .id_load(id_load), .stall(stall),
      .fwd_cmp_rs_sel(cmp_rs), .fwd_cmp_rt_sel(cmp_rt),
      .fwd_alu_rs_sel(alu_rs), .fwd_alu_rt_sel(alu_rt)
   );

   fwd_hazard_unit #(.LOAD_LAT(2)) u_dut_ll2 (
      .CLK(CLK), .RESET(RESET), .id_valid(id_valid), .flush_id(flush_id),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_branch(id_branch), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
      .id_load(id_load), .stall(stall2),
      .fwd_cmp_rs_sel(cmp_rs2), .fwd_cmp_rt_sel(cmp_rt2),
      .fwd_alu_rs_sel(alu_rs2), .fwd_alu_rt_sel(alu_rt2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       rst, v, fl;
      logic [4:0] rs, rt;
      logic       urs, urt, br, we;
      logic [4:0] wr;
      logic       ld;
      logic       e_stall;
      logic [1:0] e_crs, e_crt, e_ars, e_art;
   } vec_t;

   localparam int NV = 32;
   vec_t vecs [NV];
   int   errors = 0;
   int   checks = 0;

   function automatic vec_t mk(input int rst, v, fl, rs, rt, urs, urt, br, we, wr, ld,
                               input int es, crs, crt, ars, art);
      vec_t t;
      t.rst = 1'(rst);  t.v   = 1'(v);   t.fl  = 1'(fl);
      t.rs  = 5'(rs);   t.rt  = 5'(rt);
      t.urs = 1'(urs);  t.urt = 1'(urt); t.br  = 1'(br);  t.we = 1'(we);
      t.wr  = 5'(wr);   t.ld  = 1'(ld);
      t.e_stall = 1'(es);
      t.e_crs = 2'(crs); t.e_crt = 2'(crt); t.e_ars = 2'(ars); t.e_art = 2'(art);
      return t;
   endfunction

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      RESET     = t.rst;  id_valid  = t.v;   flush_id  = t.fl;
      id_rs     = t.rs;   id_rt     = t.rt;
      id_use_rs = t.urs;  id_use_rt = t.urt; id_branch = t.br;
      id_wr_en  = t.we;   id_wr_reg = t.wr;  id_load   = t.ld;
   endtask

   // One ID cycle: comb outputs mid-cycle, registered selects after the edge
   task automatic run_vec(input vec_t t, input int n);
      drive(t);
      #3;
      chk($sformatf("v%0d_stall", n), 2'(stall), 2'(t.e_stall));
      if (!t.e_stall) begin
         chk($sformatf("v%0d_cmp_rs", n), cmp_rs, t.e_crs);
         chk($sformatf("v%0d_cmp_rt", n), cmp_rt, t.e_crt);
      end
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_alu_rs", n), alu_rs, t.e_ars);
      chk($sformatf("v%0d_alu_rt", n), alu_rt, t.e_art);
   endtask

   initial begin
      //            rst v fl rs rt urs urt br we wr ld | st crs crt ars art
      vecs[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // reset
      vecs[1]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
      vecs[2]  = mk(0, 1, 0, 6, 7,  1, 1, 0, 1, 5, 0,   0, 0, 0, 0, 0);  // add r5,r6,r7
      vecs[3]  = mk(0, 1, 0, 5, 1,  1, 1, 0, 1, 8, 0,   0, 0, 0, 1, 0);  // sub r8,r5,r1
      vecs[4]  = mk(0, 1, 0, 1, 2,  1, 1, 0, 1, 3, 0,   0, 0, 0, 0, 0);  // add r3,r1,r2
      vecs[5]  = mk(0, 1, 0, 3, 1,  1, 1, 0, 1, 9, 0,   0, 0, 0, 1, 0);  // sub r9,r3,r1
      vecs[6]  = mk(0, 1, 0, 1, 3,  1, 1, 0, 1, 10, 0,  0, 0, 0, 0, 2);  // or r10,r1,r3
      vecs[7]  = mk(0, 1, 0, 1, 0,  1, 0, 0, 1, 4, 1,   0, 0, 0, 0, 0);  // lw r4
      vecs[8]  = mk(0, 1, 0, 4, 4,  1, 1, 0, 1, 2, 0,   1, 0, 0, 0, 0);  // add r2,r4,r4 stall
      vecs[9]  = mk(0, 1, 0, 4, 4,  1, 1, 0, 1, 2, 0,   0, 0, 0, 2, 2);  // retry
      vecs[10] = mk(0, 1, 0, 1, 1,  1, 1, 0, 1, 6, 0,   0, 0, 0, 0, 0);  // add r6,r1,r1
      vecs[11] = mk(0, 1, 0, 6, 0,  1, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0);  // beq r6,r0
      vecs[12] = mk(0, 1, 0, 6, 0,  1, 1, 1, 0, 0, 0,   NC, C, 0, 2*C, 0);
      vecs[13] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
      vecs[14] = mk(0, 1, 0, 1, 0,  1, 0, 0, 1, 2, 1,   0, 0, 0, 0, 0);  // lw r2
      vecs[15] = mk(0, 1, 0, 2, 0,  1, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0);  // beq r2,r0
      vecs[16] = mk(0, 1, 0, 2, 0,  1, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0);
      vecs[17] = mk(0, 1, 0, 2, 0,  1, 1, 1, 0, 0, 0,   NC, 2*C, 0, 0, 0);
      vecs[18] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
      vecs[19] = mk(0, 1, 0, 1, 1,  1, 1, 0, 1, 3, 0,   0, 0, 0, 0, 0);  // add r3
      vecs[20] = mk(0, 1, 0, 3, 0,  1, 0, 0, 1, 3, 0,   0, 0, 0, 1, 0);  // addi r3,r3
      vecs[21] = mk(0, 1, 0, 3, 1,  1, 1, 0, 1, 11, 0,  0, 0, 0, 1, 0);  // sub r11,r3,r1
      vecs[22] = mk(0, 1, 0, 1, 1,  1, 1, 0, 1, 7, 0,   0, 0, 0, 0, 0);  // add r7
      vecs[23] = mk(0, 1, 0, 1, 0,  1, 0, 0, 1, 7, 1,   0, 0, 0, 0, 0);  // lw r7
      vecs[24] = mk(0, 1, 0, 7, 1,  1, 1, 0, 1, 13, 0,  1, 0, 0, 0, 0);  // youngest is load
      vecs[25] = mk(0, 1, 0, 7, 1,  1, 1, 0, 1, 13, 0,  0, 0, 0, 2, 0);
      vecs[26] = mk(0, 1, 0, 1, 1,  1, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0);  // add r0
      vecs[27] = mk(0, 1, 0, 0, 0,  1, 1, 0, 1, 14, 0,  0, 0, 0, 0, 0);  // add r14,r0,r0
      vecs[28] = mk(0, 1, 0, 14, 14, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1);  // rs unused
      vecs[29] = mk(0, 1, 1, 14, 14, 1, 1, 0, 1, 15, 0, 0, 0, 0, 0, 0);  // flushed
      vecs[30] = mk(0, 1, 0, 15, 15, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);  // r15 never written
      vecs[31] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

      drive(vecs[0]);
      #1;
      for (int n = 0; n < NV; n++) run_vec(vecs[n], n);

      // Flush during a load-use stall: stall drops in the same cycle
      drive(mk(0, 1, 0, 1, 0, 1, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0));
      #3; chk("flush_lw_stall", 2'(stall), 2'd0);
      @(posedge CLK); #1;
      drive(mk(0, 1, 0, 4, 4, 1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0));
      #3; chk("flush_pre_stall", 2'(stall), 2'd1);
      flush_id = 1'b1;
      #1; chk("flush_stall_drop", 2'(stall), 2'd0);
      @(posedge CLK); #1;
      chk("flush_alu_rs", alu_rs, 2'd0);
      chk("flush_alu_rt", alu_rt, 2'd0);
      drive(mk(0, 1, 0, 4, 4, 1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0));
      #3; chk("flush_retry_stall", 2'(stall), 2'd0);
      @(posedge CLK); #1;
      chk("flush_retry_alu_rs", alu_rs, 2'd2);
      chk("flush_retry_alu_rt", alu_rt, 2'd2);

      // Reset in the middle of a stall clears the history
      drive(mk(0, 1, 0, 1, 0, 1, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0));
      @(posedge CLK); #1;
      drive(mk(1, 1, 0, 4, 4, 1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0));
      #3; chk("rst_mid_stall", 2'(stall), 2'd1);
      @(posedge CLK); #1;
      chk("rst_alu_rs", alu_rs, 2'd0);
      drive(mk(0, 1, 0, 4, 4, 1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0));
      #3; chk("rst_after_stall", 2'(stall), 2'd0);
      @(posedge CLK); #1;
      chk("rst_after_alu_rs", alu_rs, 2'd0);
      chk("rst_after_alu_rt", alu_rt, 2'd0);

      // LOAD_LAT=1 vs LOAD_LAT=2 load-use stall lengths
      drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge CLK); #1;
      drive(mk(0, 1, 0, 1, 0, 1, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0));
      @(posedge CLK); #1;
      drive(mk(0, 1, 0, 4, 4, 1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0));
      #3; chk("ll1_c1_stall", 2'(stall), 2'd1);
          chk("ll2_c1_stall", 2'(stall2), 2'd1);
      @(posedge CLK); #4;
          chk("ll1_c2_stall", 2'(stall), 2'd0);
          chk("ll2_c2_stall", 2'(stall2), 2'd1);
      @(posedge CLK); #1;
          chk("ll1_c2_alu_rs", alu_rs, 2'd2);
          chk("ll2_c2_alu_rs", alu_rs2, 2'd0);
      #3; chk("ll1_c3_stall", 2'(stall), 2'd0);
          chk("ll2_c3_stall", 2'(stall2), 2'd0);
      @(posedge CLK); #1;
          chk("ll2_c3_alu_rs", alu_rs2, 2'd0);
          chk("ll2_c3_alu_rt", alu_rt2, 2'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
